// File: rtl/dispatch_stage.sv
// Registered dispatch stage: holds one decoded instruction, resolves its operands
// against regfile/ROB/CDBs, and issues it to the RS or LSB while allocating a ROB entry.
module dispatch_stage #(
   parameter int DATA_W = 32,
   parameter int ROB_W  = 4,
   parameter int REG_W  = 5,
   parameter int OP_W   = 6,
   parameter int CDB_N  = 2
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic                      rdy_in,
   input  logic                      flush_in,
   input  logic                      id_valid,
   output logic                      id_ready,
   input  logic [OP_W-1:0]           id_op,
   input  logic                      id_is_mem,
   input  logic [REG_W-1:0]          id_rd,
   input  logic [REG_W-1:0]          id_rs1,
   input  logic [REG_W-1:0]          id_rs2,
   input  logic                      id_rs1_use,
   input  logic                      id_rs2_use,
   input  logic [DATA_W-1:0]         id_imm,
   input  logic [DATA_W-1:0]         id_pc,
   input  logic                      reg_rs1_busy,
   input  logic                      reg_rs2_busy,
   input  logic [ROB_W-1:0]          reg_rs1_tag,
   input  logic [ROB_W-1:0]          reg_rs2_tag,
   input  logic [DATA_W-1:0]         reg_rs1_val,
   input  logic [DATA_W-1:0]         reg_rs2_val,
   input  logic                      rob_q1_ready,
   input  logic                      rob_q2_ready,
   input  logic [DATA_W-1:0]         rob_q1_val,
   input  logic [DATA_W-1:0]         rob_q2_val,
   input  logic                      rob_full,
   input  logic [ROB_W-1:0]          rob_nxt_tag,
   output logic                      rob_alloc,
   output logic                      reg_rename_en,
   input  logic [CDB_N-1:0]          cdb_valid,
   input  logic [CDB_N*ROB_W-1:0]    cdb_tag,
   input  logic [CDB_N*DATA_W-1:0]   cdb_val,
   input  logic                      rs_full,
   input  logic                      lsb_full,
   output logic                      iss_rs_valid,
   output logic                      iss_lsb_valid,
   output logic [OP_W-1:0]           iss_op,
   output logic [REG_W-1:0]          iss_rd,
   output logic [ROB_W-1:0]          iss_tag,
   output logic [DATA_W-1:0]         iss_pc,
   output logic [DATA_W-1:0]         iss_imm,
   output logic                      iss_qj_busy,
   output logic                      iss_qk_busy,
   output logic [DATA_W-1:0]         iss_vj,
   output logic [DATA_W-1:0]         iss_vk,
   output logic [ROB_W-1:0]          iss_qj,
   output logic [ROB_W-1:0]          iss_qk
);

   typedef enum logic {S_EMPTY, S_HELD} state_t;
   state_t state_q, state_d;

   logic [OP_W-1:0]   h_op;
   logic              h_is_mem;
   logic [REG_W-1:0]  h_rd;
   logic [DATA_W-1:0] h_pc, h_imm, h_vj, h_vk;
   logic              h_qj_busy, h_qk_busy;
   logic [ROB_W-1:0]  h_qj, h_qk;

   logic held, can_issue, accept, fwd1, fwd2;
   logic [DATA_W:0] j_hit, k_hit, r1_hit, r2_hit;
   logic              wj_busy, wk_busy;
   logic [DATA_W-1:0] wj_val, wk_val;
   logic [ROB_W-1:0]  wj_tag, wk_tag;
   logic [ROB_W+DATA_W:0] op1, op2;

   // {hit, value} of the lowest-numbered CDB broadcasting tag
   function automatic logic [DATA_W:0] cdb_match(
      input logic [ROB_W-1:0]        tag,
      input logic [CDB_N-1:0]        v,
      input logic [CDB_N*ROB_W-1:0]  tags,
      input logic [CDB_N*DATA_W-1:0] vals
   );
      logic [DATA_W:0] r;
      r = '0;
      for (int unsigned i = 0; i < CDB_N; i++) begin
         if (!r[DATA_W] && v[i] && (tags[i*ROB_W +: ROB_W] == tag))
            r = {1'b1, vals[i*DATA_W +: DATA_W]};
      end
      return r;
   endfunction

   // Capture-time operand resolution, packed as {busy, tag, value}
   function automatic logic [ROB_W+DATA_W:0] resolve(
      input logic              use_op,
      input logic              fwd,
      input logic              rbusy,
      input logic [ROB_W-1:0]  rtag,
      input logic [DATA_W-1:0] rval,
      input logic [DATA_W:0]   hit,
      input logic              rob_rdy,
      input logic [DATA_W-1:0] rob_val,
      input logic [ROB_W-1:0]  nxt_tag
   );
      if (!use_op)          return '0;
      else if (fwd)         return {1'b1, nxt_tag, {DATA_W{1'b0}}};
      else if (!rbusy)      return {1'b0, {ROB_W{1'b0}}, rval};
      else if (hit[DATA_W]) return {1'b0, {ROB_W{1'b0}}, hit[DATA_W-1:0]};
      else if (rob_rdy)     return {1'b0, {ROB_W{1'b0}}, rob_val};
      else                  return {1'b1, rtag, {DATA_W{1'b0}}};
   endfunction

   always_comb begin
      held      = (state_q == S_HELD);
      can_issue = held & !rob_full & (h_is_mem ? !lsb_full : !rs_full) & rdy_in & !flush_in;
      id_ready  = rdy_in & !flush_in & (!held | can_issue);
      accept    = id_valid & id_ready;
      fwd1      = can_issue & (h_rd != '0) & (h_rd == id_rs1);
      fwd2      = can_issue & (h_rd != '0) & (h_rd == id_rs2);

      j_hit  = cdb_match(h_qj, cdb_valid, cdb_tag, cdb_val);
      k_hit  = cdb_match(h_qk, cdb_valid, cdb_tag, cdb_val);
      r1_hit = cdb_match(reg_rs1_tag, cdb_valid, cdb_tag, cdb_val);
      r2_hit = cdb_match(reg_rs2_tag, cdb_valid, cdb_tag, cdb_val);

      wj_busy = h_qj_busy & !j_hit[DATA_W];
      wk_busy = h_qk_busy & !k_hit[DATA_W];
      wj_val  = h_qj_busy ? (j_hit[DATA_W] ? j_hit[DATA_W-1:0] : '0) : h_vj;
      wk_val  = h_qk_busy ? (k_hit[DATA_W] ? k_hit[DATA_W-1:0] : '0) : h_vk;
      wj_tag  = wj_busy ? h_qj : '0;
      wk_tag  = wk_busy ? h_qk : '0;

      op1 = resolve(id_rs1_use, fwd1, reg_rs1_busy, reg_rs1_tag, reg_rs1_val,
                    r1_hit, rob_q1_ready, rob_q1_val, rob_nxt_tag);
      op2 = resolve(id_rs2_use, fwd2, reg_rs2_busy, reg_rs2_tag, reg_rs2_val,
                    r2_hit, rob_q2_ready, rob_q2_val, rob_nxt_tag);
   end

   always_comb begin
      iss_rs_valid  = can_issue & !h_is_mem;
      iss_lsb_valid = can_issue & h_is_mem;
      rob_alloc     = can_issue;
      reg_rename_en = can_issue & (h_rd != '0);
      iss_tag       = can_issue ? rob_nxt_tag : '0;
      iss_op        = held ? h_op    : '0;
      iss_rd        = held ? h_rd    : '0;
      iss_pc        = held ? h_pc    : '0;
      iss_imm       = held ? h_imm   : '0;
      iss_qj_busy   = held & wj_busy;
      iss_qk_busy   = held & wk_busy;
      iss_vj        = held ? wj_val  : '0;
      iss_vk        = held ? wk_val  : '0;
      iss_qj        = held ? wj_tag  : '0;
      iss_qk        = held ? wk_tag  : '0;
   end

   always_comb begin
      state_d = state_q;
      if (rdy_in) begin
         if (flush_in)       state_d = S_EMPTY;
         else if (accept)    state_d = S_HELD;
         else if (can_issue) state_d = S_EMPTY;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= S_EMPTY;
      else           state_q <= state_d;
   end

   // Record is zeroed whenever the stage empties so outputs read 0 without a held gate
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         h_op <= '0; h_is_mem <= 1'b0; h_rd <= '0; h_pc <= '0; h_imm <= '0;
         h_qj_busy <= 1'b0; h_qj <= '0; h_vj <= '0;
         h_qk_busy <= 1'b0; h_qk <= '0; h_vk <= '0;
      end else if (rdy_in) begin
         if (flush_in || (!accept && can_issue)) begin
            h_op <= '0; h_is_mem <= 1'b0; h_rd <= '0; h_pc <= '0; h_imm <= '0;
            h_qj_busy <= 1'b0; h_qj <= '0; h_vj <= '0;
            h_qk_busy <= 1'b0; h_qk <= '0; h_vk <= '0;
         end else if (accept) begin
            h_op <= id_op; h_is_mem <= id_is_mem; h_rd <= id_rd;
            h_pc <= id_pc; h_imm <= id_imm;
            h_qj_busy <= op1[ROB_W+DATA_W];
            h_qj      <= op1[DATA_W +: ROB_W];
            h_vj      <= op1[DATA_W-1:0];
            h_qk_busy <= op2[ROB_W+DATA_W];
            h_qk      <= op2[DATA_W +: ROB_W];
            h_vk      <= op2[DATA_W-1:0];
         end else if (held) begin
            h_qj_busy <= wj_busy; h_qj <= wj_tag; h_vj <= wj_val;
            h_qk_busy <= wk_busy; h_qk <= wk_tag; h_vk <= wk_val;
         end
      end
   end

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed-vector bench for dispatch_stage: inputs driven 1ns after posedge,
// outputs sampled on the falling edge against hand-computed values.
module tb_dispatch_stage;
   localparam int DATA_W = 32, ROB_W = 4, REG_W = 5, OP_W = 6, CDB_N = 2;
   localparam logic [OP_W-1:0] OP_ADD = 6'h01, OP_ADDI = 6'h02, OP_LW = 6'h10;

   logic clk, rst_n, rdy_in, flush_in, id_valid, id_ready, id_is_mem;
   logic [OP_W-1:0] id_op;
   logic [REG_W-1:0] id_rd, id_rs1, id_rs2;
   logic id_rs1_use, id_rs2_use;
   logic [DATA_W-1:0] id_imm, id_pc;
   logic reg_rs1_busy, reg_rs2_busy;
   logic [ROB_W-1:0] reg_rs1_tag, reg_rs2_tag;
   logic [DATA_W-1:0] reg_rs1_val, reg_rs2_val;
   logic rob_q1_ready, rob_q2_ready;
   logic [DATA_W-1:0] rob_q1_val, rob_q2_val;
   logic rob_full, rob_alloc, reg_rename_en;
   logic [ROB_W-1:0] rob_nxt_tag;
   logic [CDB_N-1:0] cdb_valid;
   logic [CDB_N*ROB_W-1:0] cdb_tag;
   logic [CDB_N*DATA_W-1:0] cdb_val;
   logic rs_full, lsb_full, iss_rs_valid, iss_lsb_valid;
   logic [OP_W-1:0] iss_op;
   logic [REG_W-1:0] iss_rd;
   logic [ROB_W-1:0] iss_tag, iss_qj, iss_qk;
   logic [DATA_W-1:0] iss_pc, iss_imm, iss_vj, iss_vk;
   logic iss_qj_busy, iss_qk_busy;

   int unsigned n_cmp = 0, n_bad = 0;

   dispatch_stage #(.DATA_W(DATA_W), .ROB_W(ROB_W), .REG_W(REG_W), .OP_W(OP_W), .CDB_N(CDB_N)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in), .flush_in(flush_in),
      .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op), .id_is_mem(id_is_mem),
      .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use), .id_imm(id_imm), .id_pc(id_pc),
      .reg_rs1_busy(reg_rs1_busy), .reg_rs2_busy(reg_rs2_busy),
      .reg_rs1_tag(reg_rs1_tag), .reg_rs2_tag(reg_rs2_tag),
      .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val),
      .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
      .rob_q1_val(rob_q1_val), .rob_q2_val(rob_q2_val),
      .rob_full(rob_full), .rob_nxt_tag(rob_nxt_tag), .rob_alloc(rob_alloc),
      .reg_rename_en(reg_rename_en), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
      .rs_full(rs_full), .lsb_full(lsb_full), .iss_rs_valid(iss_rs_valid), .iss_lsb_valid(iss_lsb_valid),
      .iss_op(iss_op), .iss_rd(iss_rd), .iss_tag(iss_tag), .iss_pc(iss_pc), .iss_imm(iss_imm),
      .iss_qj_busy(iss_qj_busy), .iss_qk_busy(iss_qk_busy), .iss_vj(iss_vj), .iss_vk(iss_vk),
      .iss_qj(iss_qj), .iss_qk(iss_qk)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      rdy_in = 1'b1; flush_in = 1'b0; id_valid = 1'b0; id_op = '0; id_is_mem = 1'b0;
      id_rd = '0; id_rs1 = '0; id_rs2 = '0; id_rs1_use = 1'b0; id_rs2_use = 1'b0;
      id_imm = '0; id_pc = '0;
      reg_rs1_busy = 1'b0; reg_rs2_busy = 1'b0; reg_rs1_tag = '0; reg_rs2_tag = '0;
      reg_rs1_val = '0; reg_rs2_val = '0;
      rob_q1_ready = 1'b0; rob_q2_ready = 1'b0; rob_q1_val = '0; rob_q2_val = '0;
      rob_full = 1'b0; rob_nxt_tag = '0; cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
      rs_full = 1'b0; lsb_full = 1'b0;
   endtask

   task automatic instr(input logic [OP_W-1:0] op, input logic mem, input logic [REG_W-1:0] rd,
                        input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                        input logic u1, input logic u2, input logic [DATA_W-1:0] imm,
                        input logic [DATA_W-1:0] pc);
      id_valid = 1'b1; id_op = op; id_is_mem = mem; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
      id_rs1_use = u1; id_rs2_use = u2; id_imm = imm; id_pc = pc;
   endtask

   task automatic regs(input logic b1, input logic [ROB_W-1:0] t1, input logic [DATA_W-1:0] v1,
                       input logic b2, input logic [ROB_W-1:0] t2, input logic [DATA_W-1:0] v2);
      reg_rs1_busy = b1; reg_rs1_tag = t1; reg_rs1_val = v1;
      reg_rs2_busy = b2; reg_rs2_tag = t2; reg_rs2_val = v2;
   endtask

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      #2;
      chk("rst_id_ready", id_ready, 1);
      chk("rst_rs_valid", iss_rs_valid, 0);
      chk("rst_alloc", rob_alloc, 0);
      chk("rst_rename", reg_rename_en, 0);
      #8 rst_n = 1'b1;
      nxt();

      // ADD x3,x1,x2: x1=5 committed, x2 waits on tag 7
      idle(); instr(OP_ADD, 0, 3, 1, 2, 1, 1, 0, 32'h100); regs(0, 0, 5, 1, 7, 0);
      smp(); chk("add_acc_ready", id_ready, 1); chk("add_acc_noiss", iss_rs_valid, 0); nxt();
      idle(); rob_nxt_tag = 2;
      smp();
      chk("add_rs_valid", iss_rs_valid, 1); chk("add_lsb_valid", iss_lsb_valid, 0);
      chk("add_vj", iss_vj, 5); chk("add_qj_busy", iss_qj_busy, 0);
      chk("add_qk_busy", iss_qk_busy, 1); chk("add_qk", iss_qk, 7); chk("add_vk", iss_vk, 0);
      chk("add_tag", iss_tag, 2); chk("add_rename", reg_rename_en, 1);
      chk("add_alloc", rob_alloc, 1); chk("add_rd", iss_rd, 3); chk("add_pc", iss_pc, 32'h100);
      chk("add_op", iss_op, OP_ADD);
      nxt();

      // Same ADD stalled on rs_full; CDB1 wakes tag 7 mid-stall
      idle(); instr(OP_ADD, 0, 3, 1, 2, 1, 1, 0, 32'h100); regs(0, 0, 5, 1, 7, 0);
      smp(); chk("stl_prev_cleared", iss_rs_valid, 0); nxt();
      idle(); rs_full = 1;
      smp(); chk("stl1_ready", id_ready, 0); chk("stl1_noiss", iss_rs_valid, 0); chk("stl1_alloc", rob_alloc, 0); nxt();
      idle(); rs_full = 1; cdb_valid = 2'b10; cdb_tag = {4'd7, 4'd3}; cdb_val = {32'h1234, 32'hdead};
      smp(); chk("stl2_ready", id_ready, 0); chk("stl2_noiss", iss_rs_valid, 0); nxt();
      idle(); rs_full = 1;
      smp(); chk("stl3_ready", id_ready, 0); nxt();
      idle(); rob_nxt_tag = 4;
      smp();
      chk("stl_rel_valid", iss_rs_valid, 1); chk("stl_rel_qk_busy", iss_qk_busy, 0);
      chk("stl_rel_vk", iss_vk, 32'h1234); chk("stl_rel_qk", iss_qk, 0);
      chk("stl_rel_vj", iss_vj, 5); chk("stl_rel_tag", iss_tag, 4); chk("stl_rel_ready", id_ready, 1);
      nxt();

      // ADDI x4,x0,1 then ADD x5,x4,x4 back to back
      idle(); instr(OP_ADDI, 0, 4, 0, 0, 1, 0, 1, 32'h200);
      smp(); nxt();
      idle(); rob_nxt_tag = 9; instr(OP_ADD, 0, 5, 4, 4, 1, 1, 0, 32'h204); regs(0, 0, 32'h77, 0, 0, 32'h77);
      smp();
      chk("b2b1_valid", iss_rs_valid, 1); chk("b2b1_tag", iss_tag, 9); chk("b2b1_rd", iss_rd, 4);
      chk("b2b1_imm", iss_imm, 1); chk("b2b1_vj", iss_vj, 0); chk("b2b1_ready", id_ready, 1);
      nxt();
      idle(); rob_nxt_tag = 10;
      smp();
      chk("b2b2_valid", iss_rs_valid, 1); chk("b2b2_qj_busy", iss_qj_busy, 1); chk("b2b2_qj", iss_qj, 9);
      chk("b2b2_qk_busy", iss_qk_busy, 1); chk("b2b2_qk", iss_qk, 9); chk("b2b2_vj", iss_vj, 0);
      chk("b2b2_tag", iss_tag, 10); chk("b2b2_rd", iss_rd, 5);
      nxt();

      // LW x6,0(x1) blocked by lsb_full; both CDBs carry tag 5 on release, bus 0 wins
      idle(); instr(OP_LW, 1, 6, 1, 0, 1, 0, 0, 32'h300); regs(1, 5, 0, 0, 0, 0); lsb_full = 1;
      smp(); chk("lw_acc_ready", id_ready, 1); nxt();
      idle(); lsb_full = 1;
      smp(); chk("lw_blk_lsb", iss_lsb_valid, 0); chk("lw_blk_rs", iss_rs_valid, 0); chk("lw_blk_ready", id_ready, 0); nxt();
      idle(); cdb_valid = 2'b11; cdb_tag = {4'd5, 4'd5}; cdb_val = {32'hBB, 32'hAA};
      smp();
      chk("lw_lsb_valid", iss_lsb_valid, 1); chk("lw_rs_valid", iss_rs_valid, 0);
      chk("lw_qj_busy", iss_qj_busy, 0); chk("lw_vj", iss_vj, 32'hAA); chk("lw_qk_busy", iss_qk_busy, 0);
      chk("lw_alloc", rob_alloc, 1); chk("lw_rename", reg_rename_en, 1);
      nxt();

      // rd=0 instruction frozen one cycle by rdy_in, then issues without renaming
      idle(); instr(OP_ADD, 0, 0, 1, 2, 0, 0, 0, 32'h400);
      smp(); nxt();
      idle(); rdy_in = 0;
      smp(); chk("frz_valid", iss_rs_valid, 0); chk("frz_alloc", rob_alloc, 0); chk("frz_ready", id_ready, 0); nxt();
      idle();
      smp(); chk("rd0_valid", iss_rs_valid, 1); chk("rd0_alloc", rob_alloc, 1); chk("rd0_rename", reg_rename_en, 0); nxt();

      // Flush during rob_full stall, with a new instruction offered the same cycle
      idle(); instr(OP_ADD, 0, 7, 0, 0, 0, 0, 0, 32'h500);
      smp(); nxt();
      idle(); rob_full = 1;
      smp(); chk("fl_stall_ready", id_ready, 0); chk("fl_stall_alloc", rob_alloc, 0); nxt();
      idle(); rob_full = 1; flush_in = 1; instr(OP_ADD, 0, 8, 0, 0, 0, 0, 0, 32'h600);
      smp(); chk("fl_ready", id_ready, 0); chk("fl_alloc", rob_alloc, 0); nxt();
      idle();
      smp(); chk("fl_after_ready", id_ready, 1); chk("fl_after_valid", iss_rs_valid, 0); chk("fl_after_alloc", rob_alloc, 0); nxt();

      // Asynchronous reset while an instruction is issuing
      idle(); instr(OP_ADD, 0, 3, 1, 2, 1, 1, 32'h9, 32'h700); regs(0, 0, 5, 0, 0, 6);
      smp(); nxt();
      idle(); #3;
      chk("ar_pre_valid", iss_rs_valid, 1);
      rst_n = 1'b0; #1;
      chk("ar_valid", iss_rs_valid, 0); chk("ar_alloc", rob_alloc, 0); chk("ar_rename", reg_rename_en, 0);
      chk("ar_op", iss_op, 0); chk("ar_vj", iss_vj, 0); chk("ar_pc", iss_pc, 0);
      #3 rst_n = 1'b1;
      nxt();
      smp(); chk("ar_post_valid", iss_rs_valid, 0); chk("ar_post_ready", id_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dispatch_stage.md
Name: dispatch_stage

Overview:
- Registered, parametrised dispatch stage between the decoder and the RS/LSB/ROB of the Tomasulo core.
- Holds one decoded instruction and resolves rs1/rs2 to a value or ROB tag using the regfile, ROB and CDB_N broadcast buses.
- While stalled on full structures, keeps snooping the CDBs. Allocates a ROB entry, renames rd, and issues to the RS (ALU) or the LSB (memory).
- Compared with the old combinational dispatch it adds: a valid/ready handshake, stall holding, multi-CDB wakeup, back-to-back dependency forwarding, and flush.

Parameters:
DATA_W, 32, operand/pc/imm width
ROB_W, 4, ROB tag width (depth 2^ROB_W)
REG_W, 5, architectural register index width
OP_W, 6, internal opcode width
CDB_N, 2, number of common data buses snooped

Ports:
clk_in  in  1  clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global enable; low freezes the block
flush_in  in  1  mispredict flush
id_valid  in  1  decoder has an instruction
id_ready  out  1  stage accepts this cycle
id_op  in  OP_W  opcode
id_is_mem  in  1  1 = LSB target, 0 = RS target
id_rd / id_rs1 / id_rs2  in  REG_W  register indices
id_rs1_use / id_rs2_use  in  1  operand used
id_imm / id_pc  in  DATA_W  immediate, pc
reg_rs1_busy / reg_rs2_busy  in  1  regfile entry renamed
reg_rs1_tag / reg_rs2_tag  in  ROB_W  pending producer
reg_rs1_val / reg_rs2_val  in  DATA_W  committed value
rob_q1_ready / rob_q2_ready  in  1  ROB entry for reg_rsX_tag finished
rob_q1_val / rob_q2_val  in  DATA_W  its value
rob_full  in  1  no free ROB entry
rob_nxt_tag  in  ROB_W  tag of next allocation
rob_alloc  out  1  allocate ROB entry
reg_rename_en  out  1  write rob_nxt_tag into regfile Q[iss_rd]
cdb_valid  in  CDB_N  per-bus valid
cdb_tag  in  CDB_N*ROB_W  packed tags, bus i at [i*ROB_W +: ROB_W]
cdb_val  in  CDB_N*DATA_W  packed values
rs_full / lsb_full  in  1  target station full
iss_rs_valid / iss_lsb_valid  out  1  issue strobe
iss_op  out  OP_W  opcode
iss_rd  out  REG_W  destination
iss_tag  out  ROB_W  = rob_nxt_tag
iss_pc / iss_imm  out  DATA_W  pc, immediate
iss_qj_busy / iss_qk_busy  out  1  operand still waiting
iss_vj / iss_vk  out  DATA_W  operand value (0 when busy)
iss_qj / iss_qk  out  ROB_W  producer tag (0 when ready)

Behaviour:
- State: HELD flag plus a held instruction record. Reset (async, rst_n_in=0) and flush clear HELD and zero every field.
- With HELD=0 all issue, rob_alloc and reg_rename_en outputs are 0.
- can_issue = HELD & !rob_full & (id_is_mem_held ? !lsb_full : !rs_full) & rdy_in & !flush_in.
- Issue is combinational off the held record in the same cycle: iss_rs_valid/iss_lsb_valid, rob_alloc and reg_rename_en = can_issue. reg_rename_en is additionally gated by iss_rd != 0.
- id_ready = rdy_in & !flush_in & (!HELD | can_issue). Accept happens when id_valid & id_ready at the edge: capture the instruction and HELD<=1. Otherwise, if can_issue, HELD<=0.
- Minimum latency from accept to issue: 1 cycle. Back-to-back throughput: 1 per cycle.
- Operand resolution at capture, in priority order:
  - (a) use=0 → ready, value 0.
  - (b) the instruction issuing this same cycle has rd!=0 and rd==rsX → busy, tag=rob_nxt_tag.
  - (c) !reg_busy → reg_val.
  - (d) any cdb_valid[i] with cdb_tag[i]==reg_tag → that value; lowest i wins.
  - (e) rob_qX_ready → rob_qX_val.
  - (f) otherwise busy, tag=reg_tag.
- While HELD and busy: every cycle a CDB match sets the operand ready with the CDB value.
- Issue outputs also apply that cycle's CDB match combinationally, so a wakeup in the issue cycle is never lost.
- rdy_in=0: no state change, no outputs asserted.
- flush_in wins over accept and issue in the same cycle.

Test Plan:
- Reset mid-hold: capture an instruction, assert rst_n_in=0 asynchronously → HELD=0 and all issue outputs 0 immediately, before the next edge.
- ADD x3,x1,x2 with x1 committed=5, x2 busy tag 7, ROB entry 7 not ready, rob_nxt_tag=2 → next cycle iss_rs_valid=1, iss_vj=5, iss_qk_busy=1, iss_qk=7, iss_tag=2, reg_rename_en=1.
- Same instruction with rs_full=1 for 3 cycles; cdb_valid[1]=1, tag 7, value 0x1234 in cycle 2 → id_ready=0 during the stall; on release iss_qk_busy=0, iss_vk=0x1234.
- Back-to-back ADDI x4,x0,1 then ADD x5,x4,x4, rob_nxt_tag=9 at the first issue → second issue has qj=qk=9, both busy, even though the regfile reported x4 not busy.
- LW x6,0(x1) with lsb_full=1, rs_full=0 → no issue. lsb_full drops → iss_lsb_valid=1, iss_rs_valid=0.
- flush_in during a stall with rob_full=1 → HELD cleared, no rob_alloc. Next cycle id_ready=1.
